// File: rtl/mbgd_pkg.sv
// Shared defaults and controller state encoding for the MBGD phase-2 sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package mbgd_pkg;

  localparam int DW_DEF    = 8;
  localparam int N_DEF     = 8;
  localparam int N_BIT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/mbgd_tag_pipe.sv
// Tag delay line carrying {valid, column index} alongside X memory + datapath.
// Latency: L cycles; a tag pushed in cycle c pops in cycle c+L.
// Backpressure: hold freezes every stage; there is no other stall.
module mbgd_tag_pipe #(
  parameter int L  = 4,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          hold,
  input  logic          push_vld,
  input  logic [IW-1:0] push_idx,
  output logic          pop_vld,
  output logic [IW-1:0] pop_idx
);

  logic [L-1:0]         vld_q;
  logic [L-1:0][IW-1:0] idx_q;

  // shift one stage per unheld cycle; stage 0 takes the newly issued tag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      idx_q <= '0;
    end else if (!hold) begin
      vld_q[0] <= push_vld;
      idx_q[0] <= push_idx;
      for (int i = 1; i < L; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign pop_vld = vld_q[L-1];
  assign pop_idx = idx_q[L-1];

endmodule

// File: rtl/mbgd_phase2_ctrl.sv
// Phase-2 sequencer: walks the N columns of X, tags them, assembles g_vec.
// Latency: start edge to done = N + MEM_LAT + PIPE_LAT + 1 cycles plus held cycles.
// Backpressure: hold freezes FSM, counter, tags and g_vec; col_rd/dp_enable drop.
module mbgd_phase2_ctrl
  import mbgd_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int N        = N_DEF,
  parameter int N_bit    = N_BIT_DEF,
  parameter int MEM_LAT  = 1,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              hold,
  output logic              col_rd,
  output logic [N_bit-1:0]  col_addr,
  output logic              dp_enable,
  input  logic [DW-1:0]     g_in,
  output logic [DW*N-1:0]   g_vec,
  output logic              grad_valid,
  output logic              busy,
  output logic              done
);

  localparam int               L    = MEM_LAT + PIPE_LAT;
  localparam logic [N_bit-1:0] LAST = N_bit'(N - 1);

  ctrl_state_t      state, state_nxt;
  logic [N_bit-1:0] cnt, cnt_nxt;
  logic             gv_nxt;
  logic             rd_q;
  logic [N_bit-1:0] addr_q;
  logic             pop_vld;
  logic [N_bit-1:0] pop_idx;
  logic             last_cap;

  // read strobe is registered one cycle behind ISSUE; a held cycle must not read
  assign col_rd    = rd_q & ~hold;
  assign col_addr  = addr_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dp_enable = busy & ~hold;
  // tags leave in issue order, so the last column's tag marks completion
  assign last_cap  = pop_vld & (pop_idx == LAST);

  mbgd_tag_pipe #(
    .L  (L),
    .IW (N_bit)
  ) u_tag_pipe (
    .clk      (clk),
    .resetn   (resetn),
    .hold     (hold),
    .push_vld (col_rd),
    .push_idx (addr_q),
    .pop_vld  (pop_vld),
    .pop_idx  (pop_idx)
  );

  // next-state, column counter and grad_valid update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gv_nxt    = grad_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          cnt_nxt   = '0;
          gv_nxt    = 1'b0;
        end
      end
      ISSUE: begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_cap) begin
          state_nxt = DONE;
          gv_nxt    = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = ISSUE;
          cnt_nxt   = '0;
          gv_nxt    = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control registers; hold freezes all of them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      grad_valid <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
    end else if (!hold) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      grad_valid <= gv_nxt;
      rd_q       <= (state == ISSUE);
      addr_q     <= cnt;
    end
  end

  // gradient register file: store g_in verbatim into the slot named by the tag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      g_vec <= '0;
    end else if (!hold && pop_vld) begin
      g_vec[int'(pop_idx)*DW +: DW] <= g_in;
    end
  end

endmodule

// File: tb/tb_mbgd_phase2_ctrl.sv
// Scoreboard bench for mbgd_phase2_ctrl: default instance plus a N=4, L=7 instance.
// Latency: n/a.
// Backpressure: hold schedule is randomized and directed.
module tb_mbgd_phase2_ctrl;

  localparam int N1 = 8;
  localparam int L1 = 4;
  localparam int L2 = 7;

  typedef struct { int cyc; int addr; } rd_t;
  typedef struct { int cyc; logic [63:0] gv; } dn_t;

  logic        clk = 1'b0;
  logic        resetn, start, hold;
  logic        col_rd, dp_enable, grad_valid, busy, done;
  logic [2:0]  col_addr;
  logic [7:0]  g_in;
  logic [63:0] g_vec;

  logic        start2, hold2;
  logic        col_rd2, dp_enable2, grad_valid2, busy2, done2;
  logic [1:0]  col_addr2;
  logic [7:0]  g_in2;
  logic [31:0] g_vec2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bit hold_at  [4096];
  bit start_at [4096];
  bit exp_busy [4096];
  bit exp_gv   [4096];
  rd_t rd_q[$];
  dn_t done_q[$];

  logic [63:0] dat1_v;
  logic [31:0] dat2_v;
  int line1[$];
  int line2[$];

  int s, t1, t2;
  logic [63:0] d1, d2;

  mbgd_phase2_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .hold(hold),
    .col_rd(col_rd), .col_addr(col_addr), .dp_enable(dp_enable),
    .g_in(g_in), .g_vec(g_vec), .grad_valid(grad_valid), .busy(busy), .done(done)
  );

  mbgd_phase2_ctrl #(.DW(8), .N(4), .N_bit(2), .MEM_LAT(2), .PIPE_LAT(5)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .hold(hold2),
    .col_rd(col_rd2), .col_addr(col_addr2), .dp_enable(dp_enable2),
    .g_in(g_in2), .g_vec(g_vec2), .grad_valid(grad_valid2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: every event of a run happens after a fixed number of
  // unheld cycles counted from the start edge s; held cycles simply don't count.
  task automatic plan(input int s_edge, input logic [63:0] dv, output int t);
    int  u;
    int  c;
    rd_t r;
    dn_t d;
    start_at[s_edge-1] = 1'b1;
    u = 0;
    c = s_edge;
    while (u < N1 + L1 + 1) begin
      if (!hold_at[c]) begin
        if (u >= 1 && u <= N1) begin
          r.cyc  = c;
          r.addr = u - 1;
          rd_q.push_back(r);
        end
        u++;
      end
      c++;
    end
    t = c;
    d.cyc = t;
    d.gv  = dv;
    done_q.push_back(d);
    for (int k = s_edge; k <= t; k++) exp_busy[k] = 1'b1;
    for (int k = s_edge; k < t; k++) exp_gv[k] = 1'b0;
    for (int k = t; k < 4096; k++) exp_gv[k] = 1'b1;
  endtask

  // stimulus driver: hold and start follow the per-cycle schedule
  always @(posedge clk) begin
    #1;
    hold  = hold_at[cyc];
    start = start_at[cyc];
  end

  // datapath + X memory stand-in for dut: a read returns its column word L1 unheld cycles later
  always begin
    int  nin;
    bit  hh;
    @(negedge clk);
    nin = col_rd ? int'(col_addr) : -1;
    hh  = hold;
    @(posedge clk);
    #1;
    if (!hh) begin
      line1.push_back(nin);
      void'(line1.pop_front());
    end
    g_in = (line1[0] >= 0) ? dat1_v[line1[0]*8 +: 8] : 8'($urandom);
  end

  // same stand-in for dut2, never held
  always begin
    int nin;
    @(negedge clk);
    nin = col_rd2 ? int'(col_addr2) : -1;
    @(posedge clk);
    #1;
    line2.push_back(nin);
    void'(line2.pop_front());
    g_in2 = (line2[0] >= 0) ? dat2_v[line2[0]*8 +: 8] : 8'($urandom);
  end

  // monitor: pops expected reads/completions when dut presents them, checks per-cycle flags
  always @(negedge clk) begin
    rd_t r;
    dn_t d;
    if (chk_en) begin
      if (col_rd) begin
        if (rd_q.size() == 0) chk("col_rd_spurious", col_rd, 0);
        else begin
          r = rd_q.pop_front();
          chk("col_rd_cycle", cyc, r.cyc);
          chk("col_addr", col_addr, r.addr);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_spurious", done, 0);
        else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("g_vec", g_vec, d.gv);
        end
      end
      chk("busy", busy, exp_busy[cyc]);
      chk("dp_enable", dp_enable, exp_busy[cyc] & ~hold);
      chk("grad_valid", grad_valid, exp_gv[cyc]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    resetn = 1'b0; start = 1'b0; hold = 1'b0; g_in = '0;
    start2 = 1'b0; hold2 = 1'b0; g_in2 = '0;
    dat1_v = '0; dat2_v = '0;
    repeat (L1) line1.push_back(-1);
    repeat (L2) line2.push_back(-1);

    // reset values
    wait_until(2);
    @(negedge clk);
    chk("rst_col_rd", col_rd, 0);
    chk("rst_col_addr", col_addr, 0);
    chk("rst_dp_enable", dp_enable, 0);
    chk("rst_g_vec", g_vec, 0);
    chk("rst_grad_valid", grad_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    wait_until(4);
    resetn = 1'b1;
    chk_en = 1'b1;

    // basic run
    s = cyc + 2;
    d1 = 64'h1716151413121110;
    dat1_v = d1;
    plan(s, d1, t1);
    wait_until(t1 + 2);

    // hold during issue, same data
    s = cyc + 2;
    hold_at[s+4] = 1'b1;
    hold_at[s+5] = 1'b1;
    plan(s, d1, t1);
    wait_until(t1 + 2);

    // start held off in idle, then a hold during drain
    s = cyc + 3;
    d1 = {$urandom, $urandom};
    dat1_v = d1;
    hold_at[s-2]  = 1'b1;
    start_at[s-2] = 1'b1;
    hold_at[s+10] = 1'b1;
    plan(s, d1, t1);
    wait_until(t1 + 2);

    // reset mid-run
    s = cyc + 2;
    d1 = {$urandom, $urandom};
    dat1_v = d1;
    plan(s, d1, t1);
    wait_until(s + 6);
    resetn = 1'b0;
    rd_q.delete();
    done_q.delete();
    for (int c = s + 6; c < 4096; c++) begin
      exp_busy[c] = 1'b0;
      exp_gv[c]   = 1'b0;
    end
    @(negedge clk);
    chk("abort_g_vec", g_vec, 0);
    chk("abort_col_addr", col_addr, 0);
    chk("abort_done", done, 0);
    wait_until(s + 8);
    resetn = 1'b1;

    // ignored starts in ISSUE/DRAIN, then back-to-back restart from DONE
    s = cyc + 3;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    dat1_v = d1;
    start_at[s+3] = 1'b1;
    start_at[s+9] = 1'b1;
    plan(s, d1, t1);
    plan(t1 + 1, d2, t2);
    wait_until(t1);
    dat1_v = d2;
    wait_until(t2 + 2);

    // randomized runs with random holds
    for (int r = 0; r < 5; r++) begin
      s = cyc + 3;
      for (int c = s - 1; c < s + 40; c++) hold_at[c] = 1'b0;
      for (int c = s; c < s + N1 + L1 + 8; c++) hold_at[c] = ($urandom_range(0, 4) == 0);
      d1 = {$urandom, $urandom};
      dat1_v = d1;
      plan(s, d1, t1);
      hold_at[t1] = 1'b0;
      wait_until(t1 + 3);
    end

    // second instance: N=4, MEM_LAT=2, PIPE_LAT=5
    dat2_v = $urandom;
    s = cyc + 1;
    start2 = 1'b1;
    wait_until(s);
    start2 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = done2;
    end
    if (!found) chk("p2_done_timeout", done2, 1);
    else begin
      chk("p2_done_cycle", cyc, s + 12);
      chk("p2_grad_valid", grad_valid2, 1);
      for (int k = 0; k < 4; k++) chk("p2_slot", g_vec2[k*8 +: 8], dat2_v[k*8 +: 8]);
    end

    wait_until(cyc + 3);
    chk("reads_outstanding", rd_q.size(), 0);
    chk("done_outstanding", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
